// File: rtl/bit_packer_pkg.sv
// Shared types and helpers for the serial-to-parallel bit packer and its checkers.
package bit_packer_pkg;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} pack_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Narrower words are zero-extended into the argument, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: collects single bits into an ascending-indexed word and
// presents it with a fill count and running parity over a valid/ready handshake.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  input  logic             flush,
  output logic             word_valid,
  output logic [0:WIDTH-1] word_data,
  output logic [CNT_W-1:0] word_count,
  output logic             word_parity,
  input  logic             word_ready
);

  pack_state_t      state;
  logic [0:WIDTH-1] shreg;
  logic [CNT_W-1:0] count;
  logic             parity;

  logic bit_take;
  logic word_take;
  logic last_bit;
  logic close_word;

  assign bit_take   = bit_valid && (state == FILL);
  assign word_take  = word_ready && (state == HOLD);
  assign last_bit   = bit_take && (count == CNT_W'(WIDTH - 1));
  // A coincident bit counts toward the word, so flush with an accept closes even at count 0.
  assign close_word = (state == FILL) &&
                      (last_bit || (flush && (bit_take || (count != '0))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the word register is reset, not left as storage, because word_data must read 0 after reset.
      state  <= FILL;
      shreg  <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bit_take) begin
            // NOTE: non-blocking, so the index decode below sees the pre-edge count.
            for (int i = 0; i < WIDTH; i++) begin
              if (count == CNT_W'(i)) shreg[i] <= bit_data;
            end
            count  <= count + CNT_W'(1);
            parity <= parity ^ bit_data;
          end
          if (close_word) state <= HOLD;
        end
        HOLD: begin
          if (word_take) begin
            state  <= FILL;
            shreg  <= '0;
            count  <= '0;
            parity <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // All handshake and word outputs come straight from registers.
  assign bit_ready   = (state == FILL);
  assign word_valid  = (state == HOLD);
  assign word_data   = shreg;
  assign word_count  = count;
  assign word_parity = parity;

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: directed handshake/reset cases at WIDTH=8 and random stalls at WIDTH=5,
// checked by a bit-queue reference model feeding a per-lane expected-word scoreboard.
module tb_bit_packer;
  import bit_packer_pkg::*;

  localparam int NL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [NL-1:0] bit_valid;
  logic [NL-1:0] bit_data;
  logic [NL-1:0] flush;
  logic [NL-1:0] word_ready;
  logic [NL-1:0] bit_ready_m;
  logic [NL-1:0] word_valid_m;
  int            words_seen [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int W  = (g == 0) ? DEFAULT_WIDTH : 5;
    localparam int CW = $clog2(W + 1);

    logic          br;
    logic          wv;
    logic          wp;
    logic [0:W-1]  wd;
    logic [CW-1:0] wc;

    bit_packer #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bit_valid  (bit_valid[g]),
      .bit_data   (bit_data[g]),
      .bit_ready  (br),
      .flush      (flush[g]),
      .word_valid (wv),
      .word_data  (wd),
      .word_count (wc),
      .word_parity(wp),
      .word_ready (word_ready[g])
    );

    assign bit_ready_m[g]  = br;
    assign word_valid_m[g] = wv;

    typedef struct {
      logic [0:W-1] data;
      int           cnt;
      bit           par;
    } word_t;

    bit    cur [$];
    word_t exp_q [$];
    word_t nw;
    bit    m_hold;

    // Reference model: bits pile up in a queue; a word is closed when the queue is full
    // or a flush arrives with something in it, then nothing moves until the word is taken.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        cur.delete();
        exp_q.delete();
        m_hold = 1'b0;
      end else if (m_hold) begin
        if (word_ready[g]) m_hold = 1'b0;
      end else begin
        if (bit_valid[g]) cur.push_back(bit_data[g]);
        if (cur.size() == W || (flush[g] && cur.size() > 0)) begin
          nw.data = '0;
          nw.par  = 1'b0;
          nw.cnt  = cur.size();
          foreach (cur[i]) begin
            nw.data[i] = cur[i];
            nw.par     = nw.par ^ cur[i];
          end
          exp_q.push_back(nw);
          cur.delete();
          m_hold = 1'b1;
        end
      end
    end

    // Monitor: handshake levels every cycle, word contents against the scoreboard head.
    always @(negedge clk) begin
      if (!rst) begin
        check($sformatf("lane%0d bit_ready", g), 64'(br), 64'(!m_hold));
        check($sformatf("lane%0d word_valid", g), 64'(wv), 64'(m_hold));
        if (wv) begin
          if (exp_q.size() == 0) begin
            check($sformatf("lane%0d unexpected word", g), 64'(wd), 64'(0));
          end else begin
            check($sformatf("lane%0d word_data", g), 64'(wd), 64'(exp_q[0].data));
            check($sformatf("lane%0d word_count", g), 64'(wc), 64'(exp_q[0].cnt));
            check($sformatf("lane%0d word_parity", g), 64'(wp), 64'(exp_q[0].par));
            check($sformatf("lane%0d parity_of", g), 64'(wp), 64'(parity_of(32'(wd))));
            if (word_ready[g]) begin
              void'(exp_q.pop_front());
              words_seen[g]++;
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; holds the bit until accepted.
  task automatic send_bit(input int l, input logic b, input logic fl);
    int t;
    t = 0;
    bit_valid[l] = 1'b1;
    bit_data[l]  = b;
    flush[l]     = fl;
    while (!bit_ready_m[l]) begin
      if (t > 200) begin
        check($sformatf("lane%0d send timeout", l), 64'(0), 64'(1));
        break;
      end
      t++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bit_valid[l] = 1'b0;
    flush[l]     = 1'b0;
  endtask

  task automatic send_bits(input int l, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(l, bits[n-1-i], 1'b0);
  endtask

  task automatic pulse_flush(input int l);
    flush[l] = 1'b1;
    @(posedge clk);
    #1;
    flush[l] = 1'b0;
  endtask

  // Raise reset between clock edges and confirm the outputs clear without an edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, " word_valid"}, 64'(g_lane[0].wv), 64'(0));
    check({tag, " bit_ready"}, 64'(g_lane[0].br), 64'(1));
    check({tag, " word_data"}, 64'(g_lane[0].wd), 64'(0));
    check({tag, " word_count"}, 64'(g_lane[0].wc), 64'(0));
    check({tag, " word_parity"}, 64'(g_lane[0].wp), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cyc;
    bit_valid  = '0;
    bit_data   = '0;
    flush      = '0;
    word_ready = '1;
    foreach (words_seen[i]) words_seen[i] = 0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("reset word_valid", 64'(g_lane[0].wv), 64'(0));
    check("reset bit_ready", 64'(g_lane[0].br), 64'(1));
    check("reset word_data", 64'(g_lane[0].wd), 64'(0));
    check("reset word_count", 64'(g_lane[0].wc), 64'(0));
    check("reset word_parity", 64'(g_lane[0].wp), 64'(0));
    idle(2);
    rst = 1'b0;
    idle(1);

    // Full word back-to-back; word 10110010, parity 0.
    send_bits(0, 32'b10110010, 8);
    idle(3);

    // Partial word closed by flush: 111 -> 11100000, count 3, parity 1.
    send_bits(0, 32'b111, 3);
    pulse_flush(0);
    idle(2);
    check("count restarts after transfer", 64'(g_lane[0].wc), 64'(0));

    // Flush on an empty word is ignored; flush with the 5th bit includes it.
    pulse_flush(0);
    check("empty flush no word", 64'(g_lane[0].wv), 64'(0));
    idle(2);
    send_bits(0, 32'b0110, 4);
    send_bit(0, 1'b1, 1'b1);
    idle(3);

    // Consumer stalls 10 cycles while the producer keeps offering bits.
    word_ready[0] = 1'b0;
    send_bits(0, 32'b11001010, 8);
    bit_valid[0] = 1'b1;
    repeat (10) begin
      bit_data[0] = 1'($urandom_range(0, 1));
      idle(1);
    end
    bit_valid[0]  = 1'b0;
    word_ready[0] = 1'b1;
    idle(2);
    send_bits(0, 32'b01110001, 8);
    idle(3);

    // Reset mid-word, then during HOLD; neither partial nor held word may appear.
    send_bits(0, 32'b1011, 4);
    async_reset("rst mid-word");
    send_bits(0, 32'b10000001, 8);
    idle(3);
    word_ready[0] = 1'b0;
    send_bits(0, 32'b11111110, 8);
    idle(2);
    async_reset("rst in HOLD");
    word_ready[0] = 1'b1;
    send_bits(0, 32'b00101101, 8);
    idle(3);
    check("lane0 words delivered", 64'(words_seen[0]), 64'(7));

    // Random valid/ready/flush traffic on the WIDTH=5 lane.
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      bit_valid[1]  = ($urandom_range(0, 3) != 0);
      bit_data[1]   = 1'($urandom_range(0, 1));
      flush[1]      = ($urandom_range(0, 15) == 0);
      word_ready[1] = ($urandom_range(0, 2) != 0);
      if (bit_valid[1] && bit_ready_m[1]) acc++;
      idle(1);
      cyc++;
    end
    bit_valid[1]  = 1'b0;
    flush[1]      = 1'b0;
    word_ready[1] = 1'b1;
    idle(3);
    pulse_flush(1);
    idle(4);
    check("lane1 bits accepted", 64'(acc), 64'(1000));
    check("lane1 scoreboard drained", 64'(g_lane[1].exp_q.size()), 64'(0));
    check("lane1 enough words", 64'(words_seen[1] >= 200), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
